// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller sharing one 4-bit ripple-carry adder
// across ADD, MUL (shift-and-add), 8-bit ACC and CLR operations.
module alu_sequencer (
    input  logic       clock_i,
    input  logic       reset_b_i,
    input  logic       start_i,
    input  logic [1:0] function_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] result_o,
    output logic       ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_MUL = 2'b01;
    localparam logic [1:0] FN_ACC = 2'b10;
    localparam logic [1:0] FN_CLR = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [1:0] fn_q, fn_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] p_q, p_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] lo_q, lo_d;
    logic       cy_q, cy_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;

    logic [3:0] add_x, add_y, add_s;
    logic       add_cin, add_c;
    logic [4:0] chain;
    logic       last;
    logic       accept;

    // Operand steering into the single shared adder
    always_comb begin
        add_x   = 4'h0;
        add_y   = 4'h0;
        add_cin = 1'b0;
        case (fn_q)
            FN_ADD: begin
                add_x = a_q;
                add_y = b_q;
            end
            FN_MUL: begin
                add_x = p_q[7:4];
                add_y = p_q[0] ? a_q : 4'h0;
            end
            FN_ACC: begin
                if (step_q == 2'd0) begin
                    add_x = acc_q[3:0];
                    add_y = a_q;
                end else begin
                    add_x   = acc_q[7:4];
                    add_cin = cy_q;
                end
            end
            default: begin
                add_x = 4'h0;
            end
        endcase
    end

    always_comb begin
        chain    = 5'b0;
        chain[0] = add_cin;
        add_s    = 4'h0;
        for (int i = 0; i < 4; i++) begin
            add_s[i]   = add_x[i] ^ add_y[i] ^ chain[i];
            chain[i+1] = (add_x[i] & add_y[i])
                       | (chain[i] & (add_x[i] ^ add_y[i]));
        end
        add_c = chain[4];
    end

    always_comb begin
        case (fn_q)
            FN_MUL:  last = (step_q == 2'd3);
            FN_ACC:  last = (step_q == 2'd1);
            default: last = (step_q == 2'd0);
        endcase
    end

    assign accept = start_i && (state_q != EXEC);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cy_d     = cy_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: state_d = IDLE;
            EXEC: begin
                step_d = step_q + 2'd1;
                if (last) state_d = DONE;
                case (fn_q)
                    FN_ADD: begin
                        result_d = {3'b000, add_c, add_s};
                        ovf_d    = 1'b0;
                    end
                    FN_MUL: begin
                        p_d = {add_c, add_s, p_q[3:1]};
                        if (last) begin
                            result_d = {add_c, add_s, p_q[3:1]};
                            ovf_d    = 1'b0;
                        end
                    end
                    FN_ACC: begin
                        if (step_q == 2'd0) begin
                            lo_d = add_s;
                            cy_d = add_c;
                        end else begin
                            acc_d    = {add_s, lo_q};
                            result_d = {add_s, lo_q};
                            ovf_d    = add_c;
                        end
                    end
                    default: begin
                        acc_d    = 8'h00;
                        result_d = 8'h00;
                        ovf_d    = 1'b0;
                    end
                endcase
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept is legal from IDLE and DONE (back-to-back)
        if (accept) begin
            state_d = EXEC;
            step_d  = 2'd0;
            fn_d    = function_i;
            a_d     = a_i;
            b_d     = b_i;
            p_d     = {4'h0, b_i};
        end
    end

    always_ff @(posedge clock_i or negedge reset_b_i) begin
        if (!reset_b_i) begin
            state_q  <= IDLE;
            step_q   <= 2'd0;
            fn_q     <= 2'd0;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            p_q      <= 8'h00;
            acc_q    <= 8'h00;
            lo_q     <= 4'h0;
            cy_q     <= 1'b0;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q == EXEC);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign ovf_o    = ovf_q;

endmodule
